lane_serializer: RTL and testbench

//  Upstream feeder for the 16-to-1 select mux in the neuron/synapse datapath. Accepts one
//  16-lane word (16 x BIT_WIDTH) per valid/ready handshake, registers it, and walks the mux

---
 rtl/lane_serializer_pkg.sv | 15 +
 rtl/lane_serializer_mux.sv | 17 +
 rtl/lane_serializer.sv | 131 +++++++++++++
 tb/tb_lane_serializer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_serializer_pkg.sv
// Shared constants and FSM state type for the lane serializer.
//   LaneCnt  : lanes per input word (fixed by the 4-bit mux select)
//   LaneIdxW : width of a lane index / mux select
//   state_e  : serializer FSM states
package lane_serializer_pkg;

  localparam int unsigned LaneCnt  = 16;
  localparam int unsigned LaneIdxW = 4;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/lane_serializer_mux.sv
// 16-to-1 lane select mux feeding the neuron/synapse datapath.
//   lanes_i : 16 packed lanes, lane k at [k*BIT_WIDTH +: BIT_WIDTH]
//   sel_i   : lane select
//   data_o  : selected lane
module lane_serializer_mux
  import lane_serializer_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 16
) (
  input  logic [LaneCnt*BIT_WIDTH-1:0] lanes_i,
  input  logic [LaneIdxW-1:0]          sel_i,
  output logic [BIT_WIDTH-1:0]         data_o
);

  assign data_o = lanes_i[sel_i*BIT_WIDTH +: BIT_WIDTH];

endmodule

// File: rtl/lane_serializer.sv
// Lane serializer: accepts one 16-lane word per valid/ready handshake and emits one lane per
// cycle on a valid/ready output stream, optionally skipping all-zero lanes.
//   i_clk, i_rst              : clock, asynchronous active-high reset
//   i_in_valid/o_in_ready     : input word handshake
//   i_in_data                 : 16 lanes of BIT_WIDTH bits, lane k at [k*BIT_WIDTH +: BIT_WIDTH]
//   i_skip_zero               : sampled with the word; suppress lanes equal to zero
//   o_out_valid/i_out_ready   : output element handshake
//   o_out_data, o_out_idx     : selected lane value and its index
//   o_out_last                : final element of the current word
//   o_drop                    : one-cycle pulse when an all-zero skip word was discarded
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned NUM_LANES = 16  // must equal LaneCnt
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [NUM_LANES*BIT_WIDTH-1:0] i_in_data,
  input  logic                           i_skip_zero,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [BIT_WIDTH-1:0]           o_out_data,
  output logic [LaneIdxW-1:0]            o_out_idx,
  output logic                           o_out_last,
  output logic                           o_drop
);

  localparam int unsigned WordW = NUM_LANES * BIT_WIDTH;

  // Lowest set bit of m at or above position from; 0 when none.
  function automatic logic [LaneIdxW-1:0] first_set(logic [LaneCnt-1:0] m, int from);
    logic [LaneIdxW-1:0] res;
    res = '0;
    for (int i = LaneCnt - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) res = i[LaneIdxW-1:0];
    end
    return res;
  endfunction

  function automatic logic has_higher(logic [LaneCnt-1:0] m, logic [LaneIdxW-1:0] idx);
    logic res;
    res = 1'b0;
    for (int i = 0; i < LaneCnt; i++) begin
      if (m[i] && (i > int'(idx))) res = 1'b1;
    end
    return res;
  endfunction

  state_e              state_q, state_d;
  logic [WordW-1:0]    word_q, word_d;
  logic [LaneCnt-1:0]  mask_q, mask_d;
  logic [LaneIdxW-1:0] idx_q, idx_d;
  logic                drop_q, drop_d;

  logic [LaneCnt-1:0]  mask_new;
  logic                last;
  logic                load;
  logic                xfer;

  always_comb begin
    for (int k = 0; k < LaneCnt; k++) begin
      mask_new[k] = !i_skip_zero || (i_in_data[k*BIT_WIDTH +: BIT_WIDTH] != '0);
    end

    last       = (state_q == StShift) && !has_higher(mask_q, idx_q);
    // Ready drops while reset is held so no word can be lost to a reset-held load.
    o_in_ready = !i_rst && ((state_q == StIdle) || (last && i_out_ready));
    load       = i_in_valid && o_in_ready;
    xfer       = (state_q == StShift) && i_out_ready;

    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    drop_d  = 1'b0;

    // A load in SHIFT only happens alongside the last beat, so it takes priority over xfer.
    if (load) begin
      word_d = i_in_data;
      mask_d = mask_new;
      if (mask_new == '0) begin
        state_d = StIdle;
        idx_d   = '0;
        drop_d  = 1'b1;
      end else begin
        state_d = StShift;
        idx_d   = first_set(mask_new, 0);
      end
    end else if (xfer) begin
      mask_d[idx_q] = 1'b0;
      if (last) begin
        state_d = StIdle;
      end else begin
        idx_d = first_set(mask_q, int'(idx_q) + 1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  lane_serializer_mux #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_mux (
    .lanes_i(word_q),
    .sel_i  (idx_q),
    .data_o (o_out_data)
  );

  assign o_out_valid = (state_q == StShift);
  assign o_out_idx   = idx_q;
  assign o_out_last  = last;
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_lane_serializer.sv
module tb_lane_serializer;

  localparam int W  = 16;
  localparam int NL = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [NL*W-1:0] in_data;
  logic            skip;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [3:0]      out_idx;
  logic            out_last;
  logic            drop;

  lane_serializer #(
    .BIT_WIDTH(W),
    .NUM_LANES(NL)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_data  (in_data),
    .i_skip_zero(skip),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_data (out_data),
    .o_out_idx  (out_idx),
    .o_out_last (out_last),
    .o_drop     (drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   idx;
    logic         last;
  } beat_t;

  beat_t       exp_q[$];
  logic [19:0] log_q[$];  // accepted beats as {idx, data}
  bit          exp_drop = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          drop_seen = 0;
  int          streak = 0;
  int          max_streak = 0;
  bit          rand_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats of a loaded word: every lane in ascending order, zero lanes removed in skip mode.
  task automatic model_load(input logic [NL*W-1:0] d, input logic s, output bit none);
    beat_t b;
    logic [W-1:0] v;
    none = 1;
    for (int k = 0; k < NL; k++) begin
      v = d[k*W +: W];
      if (!s || v != '0) begin
        b.data = v;
        b.idx  = k[3:0];
        b.last = 1'b0;
        exp_q.push_back(b);
        none = 0;
      end
    end
    if (!none) exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  // Compare process: outputs checked every cycle mid-period, then the model advances.
  always @(negedge clk) begin
    bit exp_ready;
    bit none;
    bit nd;
    if (rst) begin
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd0);
      check("rst_drop", {31'd0, drop}, 32'd0);
      check("rst_idx", {28'd0, out_idx}, 32'd0);
      check("rst_data", {16'd0, out_data}, 32'd0);
      exp_q.delete();
      exp_drop = 0;
      streak = 0;
    end else begin
      exp_ready = (exp_q.size() == 0) || (exp_q[0].last && out_ready);
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      check("drop", {31'd0, drop}, {31'd0, exp_drop});
      if (exp_q.size() > 0) begin
        check("out_data", {16'd0, out_data}, {16'd0, exp_q[0].data});
        check("out_idx", {28'd0, out_idx}, {28'd0, exp_q[0].idx});
        check("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
      end
      if (drop) drop_seen++;
      if (out_valid) begin
        streak++;
        if (streak > max_streak) max_streak = streak;
      end else begin
        streak = 0;
      end
      if (out_valid && out_ready) log_q.push_back({out_idx, out_data});
      nd = 0;
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_ready) begin
        model_load(in_data, skip, none);
        nd = none;
      end
      exp_drop = nd;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic send(input logic [NL*W-1:0] d, input logic s);
    bit acc;
    int t;
    t = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    skip     = s;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = {8{$urandom()}};  // junk must be ignored without a load
    skip     = $urandom_range(0, 1) == 1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while (exp_q.size() != 0 || out_valid) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        check("drain_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  function automatic logic [NL*W-1:0] dense(input int mul, input int add);
    logic [NL*W-1:0] d;
    for (int k = 0; k < NL; k++) d[k*W +: W] = W'(k * mul + add);
    return d;
  endfunction

  initial begin
    logic [NL*W-1:0] d;
    int t;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    skip = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: dense word, data k+1
    log_q.delete();
    send(dense(1, 1), 1'b0);
    drain();
    check("t1_count", log_q.size(), 32'd16);
    if (log_q.size() == 16) begin
      check("t1_first", {12'd0, log_q[0]}, {12'd0, 4'd0, 16'd1});
      check("t1_last", {12'd0, log_q[15]}, {12'd0, 4'd15, 16'd16});
    end

    // 2: skip mode, three nonzero lanes
    d = '0;
    d[3*W +: W] = 16'h000A;
    d[7*W +: W] = 16'h000B;
    d[15*W +: W] = 16'h000C;
    log_q.delete();
    send(d, 1'b1);
    drain();
    check("t2_count", log_q.size(), 32'd3);
    if (log_q.size() == 3) begin
      check("t2_b0", {12'd0, log_q[0]}, {12'd0, 4'd3, 16'h000A});
      check("t2_b1", {12'd0, log_q[1]}, {12'd0, 4'd7, 16'h000B});
      check("t2_b2", {12'd0, log_q[2]}, {12'd0, 4'd15, 16'h000C});
    end

    // 3: all-zero word with skip is dropped
    log_q.delete();
    drop_seen = 0;
    send('0, 1'b1);
    repeat (4) @(negedge clk);
    check("t3_drops", drop_seen, 32'd1);
    check("t3_beats", log_q.size(), 32'd0);

    // 4: random output stalls
    log_q.delete();
    rand_ready = 1;
    send(dense(16'h111, 16'h0101), 1'b0);
    drain();
    rand_ready = 0;
    #1 out_ready = 1'b1;
    check("t4_count", log_q.size(), 32'd16);
    for (int k = 0; k < 16 && k < log_q.size(); k++)
      check("t4_order", {12'd0, log_q[k]}, {12'd0, k[3:0], 16'(k * 16'h111 + 16'h0101)});

    // 5: two dense words back to back
    log_q.delete();
    max_streak = 0;
    send(dense(2, 5), 1'b0);
    send(dense(3, 7), 1'b0);
    drain();
    check("t5_streak", max_streak, 32'd32);
    check("t5_count", log_q.size(), 32'd32);
    if (log_q.size() == 32) check("t5_w2_first", {12'd0, log_q[16]}, {12'd0, 4'd0, 16'd7});

    // 5b: zero skip word right behind a dense word
    drop_seen = 0;
    send(dense(1, 100), 1'b0);
    send('0, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    check("t5b_drops", drop_seen, 32'd1);

    // 6: reset in the middle of a dense word
    send(dense(1, 1), 1'b0);
    t = 0;
    while (!(out_valid && out_idx == 4'd5)) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        check("t6_wait_timeout", 32'd1, 32'd0);
        break;
      end
    end
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", {31'd0, out_valid}, 32'd0);
    check("t6_async_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drop_seen = 0;
    log_q.delete();
    send(dense(4, 9), 1'b0);
    drain();
    check("t6_count", log_q.size(), 32'd16);
    if (log_q.size() == 16) check("t6_first", {12'd0, log_q[0]}, {12'd0, 4'd0, 16'd9});
    check("t6_drops", drop_seen, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
